conv_bram_1d_pad_ctrl: RTL and testbench
========================================

CONV_BRAM_1D_PAD_CTRL -- requirements
Module: conv_bram_1d_pad_ctrl

Interface
REQ-001 Parameters: IMG_W=32 (unpadded image width); FILTER_L=3 (filter taps); STRIDE_W=1 (any value >=1); PAD_W=0 (zero columns on each side); RESULT_D=8 (output channels, datapath only).
REQ-002 Derived parameters: PADDED_W=IMG_W+2*PAD_W; RESULT_W=(PADDED_W-FILTER_L)/STRIDE_W+1; IMG_RAM_ADDR_WIDTH=$clog2(IMG_W); RESULT_RAM_ADDR_WIDTH=$clog2(RESULT_W); POS_WIDTH=$clog2(PADDED_W)+1; the stride counter is $clog2(STRIDE_W)+1 bits wide.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low forces the reset state immediately, independent of clk.
REQ-005 val_in  in  1  start request; accepted only when rdy_in=1.
REQ-006 rdy_in  out  1  high only in IDLE.
REQ-007 abort  in  1  synchronous cancel of the current frame.
REQ-008 img_rdaddr  out  IMG_RAM_ADDR_WIDTH  image BRAM read address; the RAM has one-cycle read latency.
REQ-009 dpath_sr_wren  out  1  shift one element into the datapath window register this cycle.
REQ-010 dpath_sr_zero  out  1  shifted element is padding; the datapath shifts in 0 instead of RAM data.
REQ-011 dpath_result_wraddr  out  RESULT_RAM_ADDR_WIDTH  result index.
REQ-012 dpath_result_wren  out  1  write the result of the completed window.
REQ-013 last_val  in  1  datapath reports the final result drained.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse when a frame completes.

Function
REQ-016 States: IDLE, FILL, SLIDE, WAIT. Any unused encoding returns to IDLE on the next cycle.
REQ-017 The block keeps a padded position counter pos (0..PADDED_W-1), a stride counter and a result index k.
REQ-018 IDLE: rdy_in=1. When val_in=1, go to FILL and set pos_next=0, k=0.
REQ-019 img_rdaddr is derived combinationally from pos_next: it equals pos_next-PAD_W when PAD_W <= pos_next < PAD_W+IMG_W; otherwise it is 0.
REQ-020 FILL and SLIDE, each cycle:
- dpath_sr_wren=1 and element pos is shifted in;
- dpath_sr_zero=1 when pos<PAD_W or pos>=PAD_W+IMG_W;
- pos increments by 1.
REQ-021 FILL ends in the cycle that pos=FILTER_L-1. The next state is SLIDE and the stride counter clears to 0.
REQ-022 A window completes in every cycle that shifts pos=FILTER_L-1+k*STRIDE_W. On completion:
- an internal wren is raised with address k;
- k increments;
- the stride counter restarts.
REQ-023 The internal wren and address are registered once. dpath_result_wren and dpath_result_wraddr therefore appear exactly one cycle after the completing shift.
REQ-024 Once the window for k=RESULT_W-1 completes, go to WAIT. Positions beyond that element are never read or shifted.
REQ-025 FILTER_L=1 completes window 0 in the first FILL cycle.
REQ-026 WAIT: dpath_sr_wren=0. When last_val=1, pulse done and go to IDLE. val_in in the same cycle is ignored.
REQ-027 An abort in FILL, SLIDE or WAIT has these effects:
- the next state is IDLE;
- dpath_sr_wren is forced 0 in the abort cycle;
- the pending registered dpath_result_wren is cleared;
- done is not pulsed.
REQ-028 An abort in IDLE has no effect. When abort and val_in are both high in IDLE, abort wins and val_in is not accepted.
REQ-029 last_val is ignored outside WAIT.
REQ-030 Elaboration fails when any of the following hold: FILTER_L>PADDED_W, STRIDE_W<1, or PAD_W>=FILTER_L.

Reset
REQ-031 While reset is low, the block holds this state:
- state=IDLE; pos, k and the stride counter are 0;
- rdy_in=1; busy=0; done=0;
- dpath_sr_wren=0; dpath_sr_zero=0;
- dpath_result_wren=0; dpath_result_wraddr=0.
REQ-032 Reset low mid-frame aborts immediately; no further wren pulses are produced after reset deasserts.

Verification
REQ-033 No padding, IMG_W=8, FILTER_L=3, STRIDE_W=1, PAD_W=0, val_in at cycle 0:
- sr_wren in cycles 1-8;
- dpath_result_wren in cycles 4-9 with addresses 0-5;
- dpath_sr_zero never asserts.
REQ-034 Padding, IMG_W=8, FILTER_L=3, PAD_W=1:
- 10 shifts; dpath_sr_zero only at pos 0 and pos 9;
- img_rdaddr never exceeds 7;
- 8 results, addresses 0-7.
REQ-035 Stride with padding, IMG_W=8, FILTER_L=3, STRIDE_W=2, PAD_W=1:
- windows end at pos 2, 4, 6, 8 and produce addresses 0-3;
- pos 9 is never shifted; WAIT is entered after pos 8.
REQ-036 Abort during SLIDE at the cycle of a completing shift:
- no dpath_result_wren follows; no done pulse;
- rdy_in=1 on the next cycle;
- a new val_in then restarts cleanly from address 0.
REQ-037 Async reset pulse mid-SLIDE, without a clock edge: all outputs go to their reset values immediately; busy=0.
REQ-038 WAIT with last_val and val_in high in the same cycle: done pulses once, the state becomes IDLE, and the frame starts only on a later val_in.

Source files
------------

// File: rtl/conv_bram_1d_pad_ctrl.sv
// Sequencer for a 1-D convolution over an image BRAM with zero padding
// and stride: walks padded positions, feeds the window register, tags results.
module conv_bram_1d_pad_ctrl #(
    parameter int IMG_W    = 32,
    parameter int FILTER_L = 3,
    parameter int STRIDE_W = 1,
    parameter int PAD_W    = 0,
    parameter int RESULT_D = 8,
    localparam int PADDED_W = IMG_W + 2 * PAD_W,
    localparam int RESULT_W = (PADDED_W - FILTER_L) / STRIDE_W + 1,
    localparam int IMG_RAM_ADDR_WIDTH = $clog2(IMG_W),
    localparam int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W),
    localparam int POS_WIDTH = $clog2(PADDED_W) + 1,
    localparam int STR_WIDTH = $clog2(STRIDE_W) + 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             val_in,
    output logic                             rdy_in,
    input  logic                             abort,
    output logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr,
    output logic                             dpath_sr_wren,
    output logic                             dpath_sr_zero,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] dpath_result_wraddr,
    output logic                             dpath_result_wren,
    input  logic                             last_val,
    output logic                             busy,
    output logic                             done
);

    if (FILTER_L > PADDED_W || STRIDE_W < 1 || PAD_W >= FILTER_L ||
        RESULT_D < 1) begin : g_bad_params
        $error("conv_bram_1d_pad_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_SLIDE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam logic [POS_WIDTH-1:0] POS_FILL_END = POS_WIDTH'(FILTER_L - 1);
    localparam logic [POS_WIDTH-1:0] POS_PAD_LO   = POS_WIDTH'(PAD_W);
    localparam logic [POS_WIDTH-1:0] POS_PAD_HI   = POS_WIDTH'(PAD_W + IMG_W);
    localparam logic [STR_WIDTH-1:0] STR_LAST     = STR_WIDTH'(STRIDE_W - 1);
    localparam logic [RESULT_RAM_ADDR_WIDTH-1:0] K_LAST =
        RESULT_RAM_ADDR_WIDTH'(RESULT_W - 1);

    state_t                           state_q, state_d;
    logic [POS_WIDTH-1:0]             pos_q, pos_d;
    logic [STR_WIDTH-1:0]             str_q, str_d;
    logic [RESULT_RAM_ADDR_WIDTH-1:0] k_q, k_d;
    logic                             wren_q, wren_d;
    logic [RESULT_RAM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                             done_q, done_d;
    logic                             sr_wren;
    logic                             win_done;

    // Next-state: position walk, window completion and abort override
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        str_d    = str_q;
        k_d      = k_q;
        sr_wren  = 1'b0;
        win_done = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pos_d = '0;
                if (val_in && !abort) begin
                    state_d = S_FILL;
                    k_d     = '0;
                    str_d   = '0;
                end
            end
            S_FILL: begin
                sr_wren = 1'b1;
                pos_d   = pos_q + 1'b1;
                if (pos_q == POS_FILL_END) begin
                    state_d  = S_SLIDE;
                    str_d    = '0;
                    win_done = 1'b1;
                end
            end
            S_SLIDE: begin
                sr_wren = 1'b1;
                pos_d   = pos_q + 1'b1;
                if (str_q == STR_LAST) begin
                    str_d    = '0;
                    win_done = 1'b1;
                end else begin
                    str_d = str_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (last_val) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (win_done) begin
            k_d = k_q + 1'b1;
            if (k_q == K_LAST) begin
                state_d = S_WAIT;
            end
        end
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            sr_wren  = 1'b0;
            win_done = 1'b0;
            done_d   = 1'b0;
        end
    end

    assign wren_d  = win_done;
    assign waddr_d = k_q;

    // Read address tracks the position shifted next cycle; padding reads 0
    always_comb begin
        img_rdaddr = '0;
        if (pos_d >= POS_PAD_LO && pos_d < POS_PAD_HI) begin
            img_rdaddr = IMG_RAM_ADDR_WIDTH'(pos_d - POS_PAD_LO);
        end
    end

    // State, counters and registered result/done strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            str_q   <= '0;
            k_q     <= '0;
            wren_q  <= 1'b0;
            waddr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            str_q   <= str_d;
            k_q     <= k_d;
            wren_q  <= wren_d;
            waddr_q <= waddr_d;
            done_q  <= done_d;
        end
    end

    assign rdy_in              = (state_q == S_IDLE);
    assign busy                = (state_q != S_IDLE);
    assign dpath_sr_wren       = sr_wren;
    assign dpath_sr_zero       = sr_wren &&
                                 (pos_q < POS_PAD_LO || pos_q >= POS_PAD_HI);
    assign dpath_result_wren   = wren_q;
    assign dpath_result_wraddr = waddr_q;
    assign done                = done_q;

endmodule

// File: tb/tb_conv_bram_1d_pad_ctrl.sv
// Directed bench: three instances (no pad, pad, pad+stride) over an
// 8-wide image, checking shift/result timing, abort, reset and handshake.
module tb_conv_bram_1d_pad_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] val, abt, lv;
    logic [2:0] rdy, bsy, dn, srw, srz, rw;
    logic [2:0] rd0, rd1, rd2;
    logic [2:0] ra0, ra1;
    logic [1:0] ra2;

    int checks;
    int errors;

    conv_bram_1d_pad_ctrl #(
        .IMG_W(8), .FILTER_L(3), .STRIDE_W(1), .PAD_W(0), .RESULT_D(8)
    ) u0 (
        .clk(clk), .reset(rst_n), .val_in(val[0]), .rdy_in(rdy[0]),
        .abort(abt[0]), .img_rdaddr(rd0), .dpath_sr_wren(srw[0]),
        .dpath_sr_zero(srz[0]), .dpath_result_wraddr(ra0),
        .dpath_result_wren(rw[0]), .last_val(lv[0]), .busy(bsy[0]),
        .done(dn[0])
    );

    conv_bram_1d_pad_ctrl #(
        .IMG_W(8), .FILTER_L(3), .STRIDE_W(1), .PAD_W(1), .RESULT_D(8)
    ) u1 (
        .clk(clk), .reset(rst_n), .val_in(val[1]), .rdy_in(rdy[1]),
        .abort(abt[1]), .img_rdaddr(rd1), .dpath_sr_wren(srw[1]),
        .dpath_sr_zero(srz[1]), .dpath_result_wraddr(ra1),
        .dpath_result_wren(rw[1]), .last_val(lv[1]), .busy(bsy[1]),
        .done(dn[1])
    );

    conv_bram_1d_pad_ctrl #(
        .IMG_W(8), .FILTER_L(3), .STRIDE_W(2), .PAD_W(1), .RESULT_D(8)
    ) u2 (
        .clk(clk), .reset(rst_n), .val_in(val[2]), .rdy_in(rdy[2]),
        .abort(abt[2]), .img_rdaddr(rd2), .dpath_sr_wren(srw[2]),
        .dpath_sr_zero(srz[2]), .dpath_result_wraddr(ra2),
        .dpath_result_wren(rw[2]), .last_val(lv[2]), .busy(bsy[2]),
        .done(dn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rdy[i] !== 1'b1 || bsy[i] !== 1'b0 || dn[i] !== 1'b0 ||
                srw[i] !== 1'b0 || srz[i] !== 1'b0 || rw[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctl u%0d rdy=%b busy=%b done=%b srw=%b srz=%b rw=%b exp 1 0 0 0 0 0",
                         i, rdy[i], bsy[i], dn[i], srw[i], srz[i], rw[i]);
            end
        end
        checks++;
        if (ra0 !== 3'd0 || ra1 !== 3'd0 || ra2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_addr got %0d %0d %0d exp 0 0 0", ra0, ra1, ra2);
        end
    endtask

    task automatic test_no_pad();
        logic ew, er;
        logic [2:0] ea, ed;
        step(); val[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b1 || rd0 !== 3'd0) begin
            errors++;
            $display("FAIL np_start rdy=%b rd=%0d exp 1 0", rdy[0], rd0);
        end
        for (int c = 1; c <= 11; c++) begin
            step(); val[0] = 1'b0;
            @(negedge clk);
            ew = (c >= 1 && c <= 8);
            er = (c >= 4 && c <= 9);
            ea = 3'(c - 4);
            ed = (c < 8) ? 3'(c) : 3'd0;
            checks++;
            if (srw[0] !== ew || srz[0] !== 1'b0 || rw[0] !== er) begin
                errors++;
                $display("FAIL np_ctl c%0d srw=%b srz=%b rw=%b exp %b 0 %b",
                         c, srw[0], srz[0], rw[0], ew, er);
            end
            if (er) begin
                checks++;
                if (ra0 !== ea) begin
                    errors++;
                    $display("FAIL np_addr c%0d got %0d exp %0d", c, ra0, ea);
                end
            end
            if (c <= 8) begin
                checks++;
                if (rd0 !== ed) begin
                    errors++;
                    $display("FAIL np_rdaddr c%0d got %0d exp %0d", c, rd0, ed);
                end
            end
        end
        step(); lv[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (bsy[0] !== 1'b1 || dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL np_wait busy=%b done=%b exp 1 0", bsy[0], dn[0]);
        end
        step(); lv[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (dn[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL np_done done=%b busy=%b exp 1 0", dn[0], bsy[0]);
        end
        step();
        @(negedge clk);
        checks++;
        if (dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL np_done_pulse done=%b exp 0", dn[0]);
        end
    endtask

    task automatic test_pad();
        logic ew, ez, er;
        logic [2:0] ea, ed;
        step(); val[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (rd1 !== 3'd0) begin
            errors++;
            $display("FAIL pad_rd0 got %0d exp 0", rd1);
        end
        for (int c = 1; c <= 13; c++) begin
            step(); val[1] = 1'b0;
            @(negedge clk);
            ew = (c >= 1 && c <= 10);
            ez = (c == 1 || c == 10);
            er = (c >= 4 && c <= 11);
            ea = 3'(c - 4);
            ed = (c >= 1 && c < 9) ? 3'(c - 1) : 3'd0;
            checks++;
            if (srw[1] !== ew || srz[1] !== ez || rw[1] !== er) begin
                errors++;
                $display("FAIL pad_ctl c%0d srw=%b srz=%b rw=%b exp %b %b %b",
                         c, srw[1], srz[1], rw[1], ew, ez, er);
            end
            if (er) begin
                checks++;
                if (ra1 !== ea) begin
                    errors++;
                    $display("FAIL pad_addr c%0d got %0d exp %0d", c, ra1, ea);
                end
            end
            if (c <= 10) begin
                checks++;
                if (rd1 !== ed) begin
                    errors++;
                    $display("FAIL pad_rdaddr c%0d got %0d exp %0d", c, rd1, ed);
                end
            end
        end
        step(); lv[1] = 1'b1;
        step(); lv[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (dn[1] !== 1'b1 || rdy[1] !== 1'b1) begin
            errors++;
            $display("FAIL pad_done done=%b rdy=%b exp 1 1", dn[1], rdy[1]);
        end
    endtask

    task automatic test_stride();
        logic ew, ez, er;
        logic [1:0] ea;
        logic [2:0] ed;
        step(); val[2] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step(); val[2] = 1'b0;
            @(negedge clk);
            ew = (c >= 1 && c <= 9);
            ez = (c == 1);
            er = (c == 4 || c == 6 || c == 8 || c == 10);
            ea = 2'((c - 4) / 2);
            ed = (c >= 1 && c < 9) ? 3'(c - 1) : 3'd0;
            checks++;
            if (srw[2] !== ew || srz[2] !== ez || rw[2] !== er) begin
                errors++;
                $display("FAIL st_ctl c%0d srw=%b srz=%b rw=%b exp %b %b %b",
                         c, srw[2], srz[2], rw[2], ew, ez, er);
            end
            if (er) begin
                checks++;
                if (ra2 !== ea) begin
                    errors++;
                    $display("FAIL st_addr c%0d got %0d exp %0d", c, ra2, ea);
                end
            end
            if (c <= 9) begin
                checks++;
                if (rd2 !== ed) begin
                    errors++;
                    $display("FAIL st_rdaddr c%0d got %0d exp %0d", c, rd2, ed);
                end
            end
            if (c >= 10) begin
                checks++;
                if (bsy[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL st_wait c%0d busy=%b exp 1", c, bsy[2]);
                end
            end
        end
        step(); lv[2] = 1'b1;
        step(); lv[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (dn[2] !== 1'b1 || bsy[2] !== 1'b0) begin
            errors++;
            $display("FAIL st_done done=%b busy=%b exp 1 0", dn[2], bsy[2]);
        end
    endtask

    task automatic test_abort();
        logic er;
        step(); val[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step(); val[0] = 1'b0;
        end
        step(); abt[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (srw[0] !== 1'b0) begin
            errors++;
            $display("FAIL ab_srw got %b exp 0", srw[0]);
        end
        step(); abt[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || rw[0] !== 1'b0) begin
            errors++;
            $display("FAIL ab_idle rdy=%b busy=%b rw=%b exp 1 0 0",
                     rdy[0], bsy[0], rw[0]);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            checks++;
            if (rw[0] !== 1'b0 || dn[0] !== 1'b0 || srw[0] !== 1'b0) begin
                errors++;
                $display("FAIL ab_quiet c%0d rw=%b done=%b srw=%b exp 0 0 0",
                         c, rw[0], dn[0], srw[0]);
            end
        end
        step(); val[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step(); val[0] = 1'b0;
            @(negedge clk);
            er = (c >= 4 && c <= 9);
            checks++;
            if (rw[0] !== er || (er && ra0 !== 3'(c - 4))) begin
                errors++;
                $display("FAIL ab_restart c%0d rw=%b addr=%0d exp %b %0d",
                         c, rw[0], ra0, er, c - 4);
            end
        end
        step(); lv[0] = 1'b1;
        step(); lv[0] = 1'b0;
    endtask

    task automatic test_async_reset();
        step(); val[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step(); val[0] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (srw[0] !== 1'b1 || bsy[0] !== 1'b1 || rw[0] !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre srw=%b busy=%b rw=%b exp 1 1 1",
                     srw[0], bsy[0], rw[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || srw[0] !== 1'b0 ||
            srz[0] !== 1'b0 || rw[0] !== 1'b0 || ra0 !== 3'd0 ||
            dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL ar_now rdy=%b busy=%b srw=%b srz=%b rw=%b addr=%0d done=%b exp 1 0 0 0 0 0 0",
                     rdy[0], bsy[0], srw[0], srz[0], rw[0], ra0, dn[0]);
        end
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            @(negedge clk);
            checks++;
            if (rw[0] !== 1'b0 || bsy[0] !== 1'b0 || srw[0] !== 1'b0) begin
                errors++;
                $display("FAIL ar_after c%0d rw=%b busy=%b srw=%b exp 0 0 0",
                         c, rw[0], bsy[0], srw[0]);
            end
        end
    endtask

    task automatic test_idle_abort();
        step(); val[0] = 1'b1; abt[0] = 1'b1; lv[0] = 1'b1;
        step(); val[0] = 1'b0; abt[0] = 1'b0; lv[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bsy[0] !== 1'b0 || rdy[0] !== 1'b1 || dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort busy=%b rdy=%b done=%b exp 0 1 0",
                     bsy[0], rdy[0], dn[0]);
        end
    endtask

    task automatic test_wait_val();
        step(); val[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step(); val[0] = 1'b0;
        end
        step(); lv[0] = 1'b1; val[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (bsy[0] !== 1'b1 || dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL wv_wait busy=%b done=%b exp 1 0", bsy[0], dn[0]);
        end
        step(); lv[0] = 1'b0; val[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (dn[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL wv_done done=%b rdy=%b busy=%b exp 1 1 0",
                     dn[0], rdy[0], bsy[0]);
        end
        step();
        @(negedge clk);
        checks++;
        if (dn[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL wv_once done=%b busy=%b exp 0 0", dn[0], bsy[0]);
        end
        step(); val[0] = 1'b1;
        step(); val[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bsy[0] !== 1'b1 || srw[0] !== 1'b1) begin
            errors++;
            $display("FAIL wv_restart busy=%b srw=%b exp 1 1", bsy[0], srw[0]);
        end
        for (int c = 2; c <= 10; c++) step();
        lv[0] = 1'b1;
        step(); lv[0] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        val    = '0;
        abt    = '0;
        lv     = '0;
        step();
        step();
        @(negedge clk);
        test_reset();
        step(); rst_n = 1'b1;
        test_no_pad();
        test_pad();
        test_stride();
        test_abort();
        test_async_reset();
        test_idle_abort();
        test_wait_val();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
